// File: rtl/vga_timing_pkg.sv
// Default 640x480 @ 60 Hz timing constants and derived raster geometry for vga_timing_gen.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int unsigned COORD_W = 10;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen: pixel coordinates, syncs, enable, strobes, frame count.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               hs;
  logic               vs;
  logic               vde;
  logic               line_start;
  logic               frame_start;
  logic               vblank_start;
  logic [15:0]        frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, vde, line_start, frame_start, vblank_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, hs, vs, vde, line_start, frame_start, vblank_start, frame_count
  );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping 0..Total-1 counter with enable; resets to Total-1 and exposes its next value.
module vga_axis_counter #(
  parameter int unsigned Total = 800,
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic [Width-1:0] count_next,
  output logic             tc
);

  localparam logic [Width-1:0] Last = Width'(Total - 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    tc      = (count_q == Last);
    count_d = count_q;
    if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= Last;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel position, active-low syncs, display enable and strobes.
// Optional macro VGA_TIMING_PIPE_EN delays hs/vs/vde by one extra register stage.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned HVisible = H_VISIBLE,
  parameter int unsigned HFront   = H_FRONT,
  parameter int unsigned HSync    = H_SYNC,
  parameter int unsigned HBack    = H_BACK,
  parameter int unsigned VVisible = V_VISIBLE,
  parameter int unsigned VFront   = V_FRONT,
  parameter int unsigned VSync    = V_SYNC,
  parameter int unsigned VBack    = V_BACK
) (
  input  logic              Clk,
  input  logic              Reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned HTotal = HVisible + HFront + HSync + HBack;
  localparam int unsigned VTotal = VVisible + VFront + VSync + VBack;

  localparam logic [COORD_W-1:0] HVis        = COORD_W'(HVisible);
  localparam logic [COORD_W-1:0] HSyncStart  = COORD_W'(HVisible + HFront);
  localparam logic [COORD_W-1:0] HSyncEnd    = COORD_W'(HVisible + HFront + HSync - 1);
  localparam logic [COORD_W-1:0] VVis        = COORD_W'(VVisible);
  localparam logic [COORD_W-1:0] VSyncStart  = COORD_W'(VVisible + VFront);
  localparam logic [COORD_W-1:0] VSyncEnd    = COORD_W'(VVisible + VFront + VSync - 1);

  if (HTotal > 1024 || VTotal > 1024) begin : g_bad_timing
    $error("vga_timing_gen: H or V total exceeds 1024");
  end

  logic [COORD_W-1:0] h_count, h_next, v_count, v_next;
  logic               h_tc, v_tc;

  vga_axis_counter #(
    .Total (HTotal),
    .Width (COORD_W)
  ) u_h_counter (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .en         (1'b1),
    .count      (h_count),
    .count_next (h_next),
    .tc         (h_tc)
  );

  vga_axis_counter #(
    .Total (VTotal),
    .Width (COORD_W)
  ) u_v_counter (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .en         (h_tc),
    .count      (v_count),
    .count_next (v_next),
    .tc         (v_tc)
  );

  logic        hs_d, vs_d, vde_d, line_d, frame_d, vblank_d;
  logic        hs_q, vs_q, vde_q, line_q, frame_q, vblank_q;
  logic [15:0] fcount_d, fcount_q;

  // Decode from the counters' next values so flags land on the same edge as the position.
  always_comb begin
    hs_d     = !((h_next >= HSyncStart) && (h_next <= HSyncEnd));
    vs_d     = !((v_next >= VSyncStart) && (v_next <= VSyncEnd));
    vde_d    = (h_next < HVis) && (v_next < VVis);
    line_d   = (h_next == '0);
    frame_d  = (h_next == '0) && (v_next == '0);
    vblank_d = (h_next == '0) && (v_next == VVis);
    fcount_d = fcount_q;
    if (h_tc && v_tc) begin
      fcount_d = fcount_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vde_q    <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
      fcount_q <= 16'hFFFF;
    end else begin
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      vde_q    <= vde_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      vblank_q <= vblank_d;
      fcount_q <= fcount_d;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  logic hs_p_q, vs_p_q, vde_p_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_p_q  <= 1'b1;
      vs_p_q  <= 1'b1;
      vde_p_q <= 1'b0;
    end else begin
      hs_p_q  <= hs_q;
      vs_p_q  <= vs_q;
      vde_p_q <= vde_q;
    end
  end

  assign vga.hs  = hs_p_q;
  assign vga.vs  = vs_p_q;
  assign vga.vde = vde_p_q;
`else
  assign vga.hs  = hs_q;
  assign vga.vs  = vs_q;
  assign vga.vde = vde_q;
`endif

  assign vga.DrawX        = h_count;
  assign vga.DrawY        = v_count;
  assign vga.line_start   = line_q;
  assign vga.frame_start  = frame_q;
  assign vga.vblank_start = vblank_q;
  assign vga.frame_count  = fcount_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default-mode and shrunk-mode generators checked against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        vde;
    logic        ls;
    logic        fs;
    logic        vbs;
    logic [15:0] fc;
  } pix_t;

  // Shrunk mode: 32 x 19 raster, 608-cycle frame, so full frames fit the run.
  localparam int unsigned SHv = 20, SHf = 3, SHs = 5, SHb = 4;
  localparam int unsigned SVv = 12, SVf = 2, SVs = 2, SVb = 3;

  logic Clk;
  logic Reset_n;

  int unsigned t;
  int          checks;
  int          errors;
  pix_t        q_d[$];
  pix_t        q_s[$];

  vga_timing_gen_if vif_d ();
  vga_timing_gen_if vif_s ();

  vga_timing_gen u_dflt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .vga     (vif_d)
  );

  vga_timing_gen #(
    .HVisible (SHv),
    .HFront   (SHf),
    .HSync    (SHs),
    .HBack    (SHb),
    .VVisible (SVv),
    .VFront   (SVf),
    .VSync    (SVs),
    .VBack    (SVb)
  ) u_small (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .vga     (vif_s)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // t = rising edges seen with reset released; t == 0 means the reset pixel.
  function automatic pix_t model_raw(input int unsigned tt, input int unsigned hv, hf, hsw, hb,
                                     input int unsigned vv, vf, vsw, vb);
    pix_t r;
    int unsigned ht, vt, p, x, line, y;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (tt == 0) begin
      r.x = 10'(ht - 1);  r.y = 10'(vt - 1);
      r.hs = 1'b1;  r.vs = 1'b1;  r.vde = 1'b0;
      r.ls = 1'b0;  r.fs = 1'b0;  r.vbs = 1'b0;
      r.fc = 16'hFFFF;
    end else begin
      p    = tt - 1;
      x    = p % ht;
      line = p / ht;
      y    = line % vt;
      r.x   = 10'(x);
      r.y   = 10'(y);
      r.hs  = !((x >= hv + hf) && (x < hv + hf + hsw));
      r.vs  = !((y >= vv + vf) && (y < vv + vf + vsw));
      r.vde = (x < hv) && (y < vv);
      r.ls  = (x == 0);
      r.fs  = (x == 0) && (y == 0);
      r.vbs = (x == 0) && (y == vv);
      r.fc  = 16'(line / vt);
    end
    return r;
  endfunction

  function automatic pix_t model(input int unsigned tt, input int unsigned hv, hf, hsw, hb,
                                 input int unsigned vv, vf, vsw, vb);
    pix_t r;
    r = model_raw(tt, hv, hf, hsw, hb, vv, vf, vsw, vb);
`ifdef VGA_TIMING_PIPE_EN
    begin
      pix_t prev;
      prev = model_raw((tt == 0) ? 0 : tt - 1, hv, hf, hsw, hb, vv, vf, vsw, vb);
      r.hs  = prev.hs;
      r.vs  = prev.vs;
      r.vde = prev.vde;
    end
`endif
    return r;
  endfunction

  function automatic string fmt(input pix_t p);
    return $sformatf("(x=%0d y=%0d hs=%b vs=%b vde=%b ls=%b fs=%b vbs=%b fc=%h)",
                     p.x, p.y, p.hs, p.vs, p.vde, p.ls, p.fs, p.vbs, p.fc);
  endfunction

  // action: 0 = none, 1 = assert reset mid-cycle, 2 = release reset mid-cycle
  task automatic cycle(input int action);
    @(posedge Clk);
    if (Reset_n) t++;
    #2;
    if (action == 1) begin
      Reset_n = 1'b0;
      t = 0;
    end else if (action == 2) begin
      Reset_n = 1'b1;
    end
    q_d.push_back(model(t, 640, 16, 96, 48, 480, 10, 2, 33));
    q_s.push_back(model(t, SHv, SHf, SHs, SHb, SVv, SVf, SVs, SVb));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(0);
  endtask

  always @(negedge Clk) begin
    pix_t e, a;
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      a.x = vif_d.DrawX;  a.y = vif_d.DrawY;
      a.hs = vif_d.hs;  a.vs = vif_d.vs;  a.vde = vif_d.vde;
      a.ls = vif_d.line_start;  a.fs = vif_d.frame_start;  a.vbs = vif_d.vblank_start;
      a.fc = vif_d.frame_count;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL dflt_pix got %s want %s", fmt(a), fmt(e));
      end
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      a.x = vif_s.DrawX;  a.y = vif_s.DrawY;
      a.hs = vif_s.hs;  a.vs = vif_s.vs;  a.vde = vif_s.vde;
      a.ls = vif_s.line_start;  a.fs = vif_s.frame_start;  a.vbs = vif_s.vblank_start;
      a.fc = vif_s.frame_count;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL small_pix got %s want %s", fmt(a), fmt(e));
      end
    end
  end

  initial begin
    t       = 0;
    checks  = 0;
    errors  = 0;
    Reset_n = 1'b0;

    run(3);
    cycle(2);
    // First run spans at least three shrunk frames and two default lines.
    run($urandom_range(2000, 2600));

    for (int k = 0; k < 3; k++) begin
      cycle(1);
      run($urandom_range(1, 3));
      cycle(2);
      run($urandom_range(900, 2500));
    end

    @(negedge Clk);
    #1;
    checks++;
    if (q_d.size() != 0 || q_s.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d/%0d pending want 0/0", q_d.size(), q_s.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
